reorder_buffer: RTL and testbench

- Circular reorder buffer that allocates rename IDs in program order and retires results in order.
- Drives the register file's rename write channels (write / write_lo) when an instruction is allocated.
- Drives the register file's commit channels (commit / commit_lo / commit_add / commit_restore) when the head entry completes.
- Sits between dispatch, the execution writeback bus and the register file.

---
 rtl/reorder_buffer.sv | 213 +++++++++++++++++++++
 tb/tb_reorder_buffer.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: in-order rename-ID allocation, out-of-order
// writeback, in-order registered commit with restore-triggered flush.
module reorder_buffer #(
  parameter int ROB_ADDR_WIDTH = 4,
  parameter int RF_ADDR_WIDTH  = 6,
  parameter int DATA_WIDTH     = 32,
  parameter int RF_REG_LO      = 33
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      alloc_en,
  input  logic                      alloc_dest_en,
  input  logic [RF_ADDR_WIDTH-1:0]  alloc_dest_addr,
  input  logic                      alloc_lo_en,
  input  logic                      alloc_add,
  input  logic                      alloc_restore,
  output logic                      alloc_ready,
  output logic [ROB_ADDR_WIDTH-1:0] alloc_id,
  output logic                      write_en,
  output logic [RF_ADDR_WIDTH-1:0]  write_addr,
  output logic [ROB_ADDR_WIDTH-1:0] write_ref_id,
  output logic                      write_lo_en,
  output logic [ROB_ADDR_WIDTH-1:0] write_lo_ref_id,
  input  logic                      wb_en,
  input  logic [ROB_ADDR_WIDTH-1:0] wb_id,
  input  logic [DATA_WIDTH-1:0]     wb_data,
  input  logic [DATA_WIDTH-1:0]     wb_lo_data,
  output logic                      commit_restore,
  output logic                      commit_add,
  output logic                      commit_en,
  output logic [RF_ADDR_WIDTH-1:0]  commit_addr,
  output logic [DATA_WIDTH-1:0]     commit_data,
  output logic                      commit_lo_en,
  output logic [DATA_WIDTH-1:0]     commit_lo_data
);

  localparam int AW    = ROB_ADDR_WIDTH;
  localparam int DEPTH = 1 << AW;
  localparam logic [RF_ADDR_WIDTH-1:0] LO_ADDR =
    RF_ADDR_WIDTH'(RF_REG_LO);

  // The lo channels carry no address: the RF targets LO_ADDR itself.
  logic unused_lo_addr;
  assign unused_lo_addr = ^LO_ADDR;

  logic [AW:0] head_q, head_d;
  logic [AW:0] tail_q, tail_d;
  logic        flush_pending_q, flush_pending_d;

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] done_q, done_d;
  logic [DEPTH-1:0] dest_en_q, dest_en_d;
  logic [DEPTH-1:0] lo_en_q, lo_en_d;
  logic [DEPTH-1:0] add_q, add_d;
  logic [DEPTH-1:0] restore_q, restore_d;

  logic [RF_ADDR_WIDTH-1:0] dest_addr_q [DEPTH];
  logic [RF_ADDR_WIDTH-1:0] dest_addr_d [DEPTH];
  logic [DATA_WIDTH-1:0]    data_q [DEPTH];
  logic [DATA_WIDTH-1:0]    data_d [DEPTH];
  logic [DATA_WIDTH-1:0]    lo_data_q [DEPTH];
  logic [DATA_WIDTH-1:0]    lo_data_d [DEPTH];

  logic                     commit_restore_q, commit_restore_d;
  logic                     commit_add_q, commit_add_d;
  logic                     commit_en_q, commit_en_d;
  logic [RF_ADDR_WIDTH-1:0] commit_addr_q, commit_addr_d;
  logic [DATA_WIDTH-1:0]    commit_data_q, commit_data_d;
  logic                     commit_lo_en_q, commit_lo_en_d;
  logic [DATA_WIDTH-1:0]    commit_lo_data_q, commit_lo_data_d;

  logic [AW-1:0] head_idx;
  logic [AW-1:0] tail_idx;
  logic          full;
  logic          fire;
  logic          dest_ok;
  logic          wb_ok;
  logic          cm;

  assign head_idx = head_q[AW-1:0];
  assign tail_idx = tail_q[AW-1:0];
  assign full     = (head_idx == tail_idx) && (head_q[AW] != tail_q[AW]);

  // Held low in reset so dispatch never sees a phantom slot.
  assign alloc_ready = rst && !full && !flush_pending_q;
  assign fire        = alloc_en && alloc_ready;
  assign dest_ok     = alloc_dest_en && (alloc_dest_addr != '0);

  assign alloc_id        = tail_idx;
  assign write_en        = fire && dest_ok;
  assign write_addr      = alloc_dest_addr;
  assign write_ref_id    = tail_idx;
  assign write_lo_en     = fire && alloc_lo_en;
  assign write_lo_ref_id = tail_idx;

  assign wb_ok = wb_en && valid_q[wb_id] && !done_q[wb_id]
              && !flush_pending_q;
  assign cm    = valid_q[head_idx] && done_q[head_idx]
              && !flush_pending_q;

  always_comb begin
    head_d           = head_q;
    tail_d           = tail_q;
    flush_pending_d  = 1'b0;
    valid_d          = valid_q;
    done_d           = done_q;
    dest_en_d        = dest_en_q;
    lo_en_d          = lo_en_q;
    add_d            = add_q;
    restore_d        = restore_q;
    dest_addr_d      = dest_addr_q;
    data_d           = data_q;
    lo_data_d        = lo_data_q;
    commit_restore_d = 1'b0;
    commit_add_d     = 1'b0;
    commit_en_d      = 1'b0;
    commit_addr_d    = '0;
    commit_data_d    = '0;
    commit_lo_en_d   = 1'b0;
    commit_lo_data_d = '0;

    if (flush_pending_q) begin
      valid_d = '0;
      done_d  = '0;
      head_d  = '0;
      tail_d  = '0;
    end else begin
      if (fire) begin
        valid_d[tail_idx]     = 1'b1;
        done_d[tail_idx]      = 1'b0;
        dest_en_d[tail_idx]   = dest_ok;
        dest_addr_d[tail_idx] = alloc_dest_addr;
        lo_en_d[tail_idx]     = alloc_lo_en;
        add_d[tail_idx]       = alloc_add;
        restore_d[tail_idx]   = alloc_restore;
        tail_d                = tail_q + 1'b1;
      end
      if (wb_ok) begin
        done_d[wb_id]    = 1'b1;
        data_d[wb_id]    = wb_data;
        lo_data_d[wb_id] = wb_lo_data;
      end
      if (cm) begin
        valid_d[head_idx] = 1'b0;
        done_d[head_idx]  = 1'b0;
        head_d            = head_q + 1'b1;
        flush_pending_d   = restore_q[head_idx];
        commit_en_d       = dest_en_q[head_idx];
        commit_addr_d     = dest_addr_q[head_idx];
        commit_data_d     = data_q[head_idx];
        commit_lo_en_d    = lo_en_q[head_idx];
        commit_lo_data_d  = lo_data_q[head_idx];
        commit_add_d      = add_q[head_idx];
        commit_restore_d  = restore_q[head_idx];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q           <= '0;
      tail_q           <= '0;
      flush_pending_q  <= 1'b0;
      valid_q          <= '0;
      done_q           <= '0;
      dest_en_q        <= '0;
      lo_en_q          <= '0;
      add_q            <= '0;
      restore_q        <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        dest_addr_q[i] <= '0;
        data_q[i]      <= '0;
        lo_data_q[i]   <= '0;
      end
      commit_restore_q <= 1'b0;
      commit_add_q     <= 1'b0;
      commit_en_q      <= 1'b0;
      commit_addr_q    <= '0;
      commit_data_q    <= '0;
      commit_lo_en_q   <= 1'b0;
      commit_lo_data_q <= '0;
    end else begin
      head_q           <= head_d;
      tail_q           <= tail_d;
      flush_pending_q  <= flush_pending_d;
      valid_q          <= valid_d;
      done_q           <= done_d;
      dest_en_q        <= dest_en_d;
      lo_en_q          <= lo_en_d;
      add_q            <= add_d;
      restore_q        <= restore_d;
      dest_addr_q      <= dest_addr_d;
      data_q           <= data_d;
      lo_data_q        <= lo_data_d;
      commit_restore_q <= commit_restore_d;
      commit_add_q     <= commit_add_d;
      commit_en_q      <= commit_en_d;
      commit_addr_q    <= commit_addr_d;
      commit_data_q    <= commit_data_d;
      commit_lo_en_q   <= commit_lo_en_d;
      commit_lo_data_q <= commit_lo_data_d;
    end
  end

  assign commit_restore = commit_restore_q;
  assign commit_add     = commit_add_q;
  assign commit_en      = commit_en_q;
  assign commit_addr    = commit_addr_q;
  assign commit_data    = commit_data_q;
  assign commit_lo_en   = commit_lo_en_q;
  assign commit_lo_data = commit_lo_data_q;

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: alloc, writeback, commit order,
// full/wrap, LO/madd, restore flush and mid-flight reset.
module tb_reorder_buffer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        alloc_en = 1'b0;
  logic        alloc_dest_en = 1'b0;
  logic [5:0]  alloc_dest_addr = '0;
  logic        alloc_lo_en = 1'b0;
  logic        alloc_add = 1'b0;
  logic        alloc_restore = 1'b0;
  logic        alloc_ready;
  logic [3:0]  alloc_id;
  logic        write_en;
  logic [5:0]  write_addr;
  logic [3:0]  write_ref_id;
  logic        write_lo_en;
  logic [3:0]  write_lo_ref_id;
  logic        wb_en = 1'b0;
  logic [3:0]  wb_id = '0;
  logic [31:0] wb_data = '0;
  logic [31:0] wb_lo_data = '0;
  logic        commit_restore;
  logic        commit_add;
  logic        commit_en;
  logic [5:0]  commit_addr;
  logic [31:0] commit_data;
  logic        commit_lo_en;
  logic [31:0] commit_lo_data;

  int total = 0;
  int bad   = 0;

  reorder_buffer dut (
    .clk(clk), .rst(rst),
    .alloc_en(alloc_en), .alloc_dest_en(alloc_dest_en),
    .alloc_dest_addr(alloc_dest_addr), .alloc_lo_en(alloc_lo_en),
    .alloc_add(alloc_add), .alloc_restore(alloc_restore),
    .alloc_ready(alloc_ready), .alloc_id(alloc_id),
    .write_en(write_en), .write_addr(write_addr),
    .write_ref_id(write_ref_id), .write_lo_en(write_lo_en),
    .write_lo_ref_id(write_lo_ref_id),
    .wb_en(wb_en), .wb_id(wb_id), .wb_data(wb_data),
    .wb_lo_data(wb_lo_data),
    .commit_restore(commit_restore), .commit_add(commit_add),
    .commit_en(commit_en), .commit_addr(commit_addr),
    .commit_data(commit_data), .commit_lo_en(commit_lo_en),
    .commit_lo_data(commit_lo_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alloc_en = 0; alloc_dest_en = 0; alloc_dest_addr = 0;
    alloc_lo_en = 0; alloc_add = 0; alloc_restore = 0;
    wb_en = 0; wb_id = 0; wb_data = 0; wb_lo_data = 0;
  endtask

  task automatic do_reset();
    idle();
    rst = 0;
    #1;
    chk("rst_cen", 32'(commit_en), 0);
    chk("rst_crs", 32'(commit_restore), 0);
    chk("rst_rdy", 32'(alloc_ready), 0);
    chk("rst_id", 32'(alloc_id), 0);
    step();
    rst = 1;
    #1;
  endtask

  task automatic alloc(input logic [5:0] a, input logic lo,
                       input logic ad, input logic rs);
    alloc_en = 1; alloc_dest_en = 1; alloc_dest_addr = a;
    alloc_lo_en = lo; alloc_add = ad; alloc_restore = rs;
  endtask

  task automatic wb(input logic [3:0] id, input logic [31:0] d,
                    input logic [31:0] lo);
    wb_en = 1; wb_id = id; wb_data = d; wb_lo_data = lo;
  endtask

  logic [5:0]  dests [3];
  logic [3:0]  wbids [3];
  logic [31:0] wbdat [3];
  logic [5:0]  c_addr [3];
  logic [31:0] c_data [3];
  logic        c_en [3];

  initial begin
    dests = '{6'd2, 6'd3, 6'd0};
    wbids = '{4'd2, 4'd1, 4'd0};
    wbdat = '{32'h30, 32'h20, 32'h10};
    c_en   = '{1'b1, 1'b1, 1'b0};
    c_addr = '{6'd2, 6'd3, 6'd0};
    c_data = '{32'h10, 32'h20, 32'h30};

    // in-order alloc with r0 suppressed
    do_reset();
    for (int i = 0; i < 3; i++) begin
      alloc(dests[i], 0, 0, 0);
      #1;
      chk("a3_id", 32'(alloc_id), 32'(i));
      chk("a3_wen", 32'(write_en), 32'(c_en[i]));
      chk("a3_ref", 32'(write_ref_id), 32'(i));
      chk("a3_rdy", 32'(alloc_ready), 1);
      step();
    end
    idle();

    // out-of-order writeback, in-order commit
    for (int i = 0; i < 3; i++) begin
      wb(wbids[i], wbdat[i], 0);
      step();
      idle();
      #1;
      chk("wb_nocm", 32'(commit_en), 0);
    end
    for (int i = 0; i < 3; i++) begin
      step();
      chk("cm_en", 32'(commit_en), 32'(c_en[i]));
      chk("cm_addr", 32'(commit_addr), 32'(c_addr[i]));
      chk("cm_data", commit_data, c_data[i]);
    end
    step();
    chk("cm_pulse", 32'(commit_en), 0);
    chk("cm_pdata", commit_data, 0);

    // fill, full, commit one, wrap
    do_reset();
    for (int i = 0; i < 16; i++) begin
      alloc(6'd5, 0, 0, 0);
      #1;
      chk("fill_id", 32'(alloc_id), 32'(i));
      chk("fill_rdy", 32'(alloc_ready), 1);
      step();
    end
    idle();
    #1;
    chk("full_rdy", 32'(alloc_ready), 0);
    chk("full_tail", 32'(dut.tail_q), 32'h10);
    chk("full_head", 32'(dut.head_q), 32'h00);
    alloc(6'd7, 0, 0, 0);
    #1;
    chk("full_wen", 32'(write_en), 0);
    step();
    idle();
    chk("full_hold", 32'(dut.tail_q), 32'h10);
    wb(4'd0, 32'h55, 0);
    step();
    idle();
    #1;
    chk("full_rdy2", 32'(alloc_ready), 0);
    step();
    chk("fc_en", 32'(commit_en), 1);
    chk("fc_data", commit_data, 32'h55);
    chk("fc_rdy", 32'(alloc_ready), 1);
    alloc(6'd5, 0, 0, 0);
    #1;
    chk("wrap_id", 32'(alloc_id), 0);
    step();
    idle();
    chk("wrap_tail", 32'(dut.tail_q), 32'h11);

    // LO / madd
    do_reset();
    alloc(6'd4, 1, 1, 0);
    #1;
    chk("lo_wen", 32'(write_en), 1);
    chk("lo_wlo", 32'(write_lo_en), 1);
    chk("lo_ref", 32'(write_lo_ref_id), 0);
    chk("lo_addr", 32'(write_addr), 4);
    step();
    idle();
    wb(4'd0, 32'd5, 32'd7);
    step();
    idle();
    step();
    chk("md_en", 32'(commit_en), 1);
    chk("md_lo", 32'(commit_lo_en), 1);
    chk("md_add", 32'(commit_add), 1);
    chk("md_data", commit_data, 5);
    chk("md_lod", commit_lo_data, 7);
    chk("md_rs", 32'(commit_restore), 0);

    // restore flush
    do_reset();
    alloc(6'd6, 0, 0, 1);
    step();
    alloc(6'd7, 0, 0, 0);
    step();
    alloc(6'd8, 0, 0, 0);
    step();
    idle();
    wb(4'd0, 32'hA, 0);
    step();
    idle();
    step();
    chk("rs_crs", 32'(commit_restore), 1);
    chk("rs_cen", 32'(commit_en), 1);
    chk("rs_addr", 32'(commit_addr), 6);
    chk("rs_data", commit_data, 32'hA);
    chk("rs_rdy", 32'(alloc_ready), 0);
    alloc(6'd9, 0, 0, 0);
    wb(4'd1, 32'hBB, 0);
    #1;
    chk("rs_wen", 32'(write_en), 0);
    step();
    idle();
    chk("rs_crs2", 32'(commit_restore), 0);
    chk("rs_head", 32'(dut.head_q), 0);
    chk("rs_tail", 32'(dut.tail_q), 0);
    chk("rs_valid", 32'(dut.valid_q), 0);
    chk("rs_rdy2", 32'(alloc_ready), 1);
    wb(4'd1, 32'hCC, 0);
    step();
    idle();
    chk("rs_late", 32'(dut.done_q), 0);
    step();
    chk("rs_nocm", 32'(commit_en), 0);
    alloc(6'd3, 0, 0, 0);
    #1;
    chk("rs_id0", 32'(alloc_id), 0);
    step();
    idle();

    // reset mid-commit
    do_reset();
    for (int i = 0; i < 6; i++) begin
      alloc(6'd9, 0, 0, 0);
      step();
    end
    idle();
    wb(4'd0, 32'h77, 0);
    step();
    idle();
    step();
    chk("mr_cen", 32'(commit_en), 1);
    rst = 0;
    #1;
    chk("mr_cen0", 32'(commit_en), 0);
    chk("mr_data0", commit_data, 0);
    chk("mr_rdy", 32'(alloc_ready), 0);
    step();
    rst = 1;
    alloc(6'd2, 0, 0, 0);
    #1;
    chk("mr_id0", 32'(alloc_id), 0);
    chk("mr_rdy2", 32'(alloc_ready), 1);
    step();
    idle();
    chk("mr_nocm", 32'(commit_en), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
